// File: rtl/paralelo_serial_param.sv
// paralelo_serial_param
// Parametrised parallel-to-serial lane serialiser in the clk32_f domain.
// Sends one WIDTH-bit symbol every WIDTH clk32_f cycles, with no gaps.
// At each symbol boundary it transmits data_in if valid_in is high, and IDLE_SYMBOL otherwise.
// The outputs are a registered serial bit, a frame-start flag on the first bit of
// every symbol, and a data/idle flag.
// Optional feature: define SER_LSB_FIRST_EN to send each symbol LSB first
// instead of MSB first.
module paralelo_serial_param #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  IDLE_SYMBOL = WIDTH'(8'hBC),
  parameter int                RESET_PHASE = 6
) (
  input  logic             clk32_f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             load_req,
  output logic             data_out,
  output logic             frame_start,
  output logic             sym_is_data
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PHASE0 = CW'(RESET_PHASE);

  // Parameter sanity: a one-bit symbol or an out-of-range start phase cannot work
  if (WIDTH < 2) begin : g_badWidth
    $error("paralelo_serial_param: WIDTH must be at least 2");
  end
  if ((RESET_PHASE < 0) || (RESET_PHASE >= WIDTH)) begin : g_badPhase
    $error("paralelo_serial_param: RESET_PHASE must lie in 0..WIDTH-1");
  end

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_isData;
  logic             r_dataOut;
  logic             r_frameStart;
  logic             r_symIsData;

  logic             w_boundary;
  logic [CW-1:0]    w_nextCnt;
  logic [WIDTH-1:0] w_nextWord;
  logic             w_firstBit;
  logic [CW-1:0]    w_bitIdx;
  logic             w_tailBit;

  // Boundary decode and the word to load there (idle unless valid data is offered)
  always_comb begin
    w_boundary = (r_cnt == '0);
    w_nextWord = valid_in ? data_in : IDLE_SYMBOL;
  end

  // Counter successor wraps explicitly at WIDTH-1, so non-power-of-2 widths never overrun
  always_comb begin
    w_nextCnt = r_cnt + 1'b1;
    if (r_cnt == LAST) begin
      w_nextCnt = '0;
    end
  end

  // Select which bit goes out: the first bit comes straight from the load mux, the rest from hold
  always_comb begin
`ifdef SER_LSB_FIRST_EN
    w_firstBit = w_nextWord[0];
    w_bitIdx   = r_cnt;
`else
    w_firstBit = w_nextWord[WIDTH-1];
    w_bitIdx   = LAST - r_cnt;
`endif
    w_tailBit  = r_hold[w_bitIdx];
  end

  // Bit counter; the reset value sets the symbol phase relative to the slower byte clock
  always_ff @(posedge clk32_f) begin
    if (reset) begin
      r_cnt <= PHASE0;
    end else begin
      r_cnt <= w_nextCnt;
    end
  end

  // Hold register and data flag capture the offered word only at the symbol boundary
  always_ff @(posedge clk32_f) begin
    if (reset) begin
      r_hold   <= IDLE_SYMBOL;
      r_isData <= 1'b0;
    end else if (w_boundary) begin
      r_hold   <= w_nextWord;
      r_isData <= valid_in;
    end
  end

  // Registered serial outputs; the boundary bit bypasses hold so that no bubble cycle appears
  always_ff @(posedge clk32_f) begin
    if (reset) begin
      r_dataOut    <= 1'b0;
      r_frameStart <= 1'b0;
      r_symIsData  <= 1'b0;
    end else if (w_boundary) begin
      r_dataOut    <= w_firstBit;
      r_frameStart <= 1'b1;
      r_symIsData  <= valid_in;
    end else begin
      r_dataOut    <= w_tailBit;
      r_frameStart <= 1'b0;
      r_symIsData  <= r_isData;
    end
  end

  // The load request is decoded from the registered counter only, never from the inputs
  always_comb begin
    load_req = (r_cnt == '0);
  end

  assign data_out    = r_dataOut;
  assign frame_start = r_frameStart;
  assign sym_is_data = r_symIsData;

endmodule
